multicycle_controller: RTL

Moore-style control FSM for the multicycle variant of our RV32I core. It sequences the shared ALU, the unified instruction/data memory port, the register file and the PC/IR registers over 3–5 cycles per instruction. It replaces the purely combinational `controlunit` when the datapath is folded onto a single memory and a single ALU. A `mem_ready` handshake lets memory stall fetch, load and store.

---
 rtl/riscv_pkg.sv | 68 ++++++
 rtl/alu_decoder.sv | 41 ++++
 rtl/multicycle_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared encodings for the multicycle RV32I control path.
//   ctrl_state_t   : state encoding of the multicycle control FSM
//   OP_*           : major opcodes (instr[6:0]) handled by the controller
//   ALUOP_*        : internal ALU operation class, FSM -> alu_decoder
//   ALU_*          : ALUControl encodings seen by the datapath ALU
//   IMM_*          : ImmSrc immediate format selects
//   RES_*          : ResultSrc selects
//   SRCA_*/SRCB_*  : ALU operand selects
// ---------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } ctrl_state_t;

    // Major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operation class produced by the FSM
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Result mux
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand muxes
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational translation of the FSM's ALU operation class into the
// datapath ALUControl code.
//   alu_op      in  2  ALUOP_ADD / ALUOP_SUB / ALUOP_FUNCT
//   funct3      in  3  instr[14:12]
//   funct7b5    in  1  instr[30]
//   op5         in  1  instr[5] (1 = register-register form)
//   alu_control out 3  ALUControl
// ---------------------------------------------------------------------------
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // instr[30] is only a sub selector for R-type; in
                    // I-type it is an immediate bit and must be ignored.
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Moore-style control FSM for the multicycle RV32I datapath (shared ALU,
// unified memory port). Outputs are combinational from the state register,
// qualified by mem_ready / EQ / funct3 where the instruction needs it.
//   clk, rst            rising-edge clock, synchronous active-high reset
//   op, funct3, funct7b5 instruction fields from IR
//   EQ                  ALU equality flag, used only in BRANCH
//   mem_ready           memory handshake for FETCH / MEMREAD / MEMWRITE
//   PCWrite, IRWrite, RegWrite, MemWrite   write enables (0 while rst)
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB    datapath mux selects
//   ALUControl          ALU operation
//   ImmSrc              immediate format, decoded from op in every state
//   illegal             one-cycle pulse in DECODE for unsupported opcodes
// ---------------------------------------------------------------------------
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       EQ,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       illegal
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;

    // Unqualified enables; rst gating is applied at the ports.
    logic       pc_write;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal_op;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        alu_op     = ALUOP_ADD;

        case (state_q)
            FETCH: begin
                // PC+4 goes straight back to PC through ALUResult while
                // the instruction word is latched into IR.
                AdrSrc    = 1'b0;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                alu_op    = ALUOP_ADD;
                ResultSrc = RES_ALURESULT;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end

            DECODE: begin
                // Precompute OldPC + imm so BRANCH/JAL find the target
                // in ALUOut.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_ADD;
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_d = MEMADR;
                    OP_R:      state_d = EXECUTER;
                    OP_I:      state_d = EXECUTEI;
                    OP_BRANCH: state_d = BRANCH;
                    OP_JAL:    state_d = JAL;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end

            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_ADD;
                // op[5] separates store (0100011) from load (0000011).
                state_d = op[5] ? MEMWRITE : MEMREAD;
            end

            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end

            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
                state_d   = FETCH;
            end

            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end
            end

            EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                alu_op  = ALUOP_FUNCT;
                state_d = ALUWB;
            end

            EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = ALUWB;
            end

            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_write = 1'b1;
                state_d   = FETCH;
            end

            BRANCH: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                alu_op    = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                case (funct3)
                    3'b000:  pc_write = EQ;
                    3'b001:  pc_write = ~EQ;
                    default: pc_write = 1'b0;
                endcase
                state_d = FETCH;
            end

            JAL: begin
                // PC takes the target from ALUOut while the ALU forms
                // OldPC+4, which ALUWB then writes to rd.
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                alu_op    = ALUOP_ADD;
                ResultSrc = RES_ALUOUT;
                pc_write  = 1'b1;
                state_d   = ALUWB;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Architectural writes are suppressed for the whole reset cycle so a
    // reset mid-instruction cannot commit anything.
    assign PCWrite  = pc_write   & ~rst;
    assign IRWrite  = ir_write   & ~rst;
    assign RegWrite = reg_write  & ~rst;
    assign MemWrite = mem_write  & ~rst;
    assign illegal  = illegal_op & ~rst;

    always_comb begin
        case (op)
            OP_LOAD,
            OP_I:      ImmSrc = IMM_I;
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

endmodule
